mc14516b_timer_ctrl: RTL

//  Programmable interval timer built around one MC14516B up/down counter.

---
 rtl/mc14516b_ctrl_pkg.sv | 20 ++
 rtl/MC14516B.sv | 42 ++++
 rtl/mc14516b_timer_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mc14516b_ctrl_pkg.sv
// rtl/mc14516b_ctrl_pkg.sv - shared types and helpers for the MC14516B interval timer
//   state_t  : controller sequencing states
//   terminal : terminal count for a given counter width and direction
package mc14516b_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Terminal count: all-ones when counting up, zero when counting down.
  function automatic logic [31:0] terminal(input int size, input logic up);
    logic [31:0] all_ones;
    all_ones = (32'd1 << size) - 32'd1;
    return up ? all_ones : 32'd0;
  endfunction

endpackage

// File: rtl/MC14516B.sv
// rtl/MC14516B.sv - behavioural MC14516B presettable up/down binary counter
//   clock         in   rising-edge count clock
//   reset         in   asynchronous active-high clear
//   preset_enable in   1 = load preset on the next clock
//   up_down       in   1 = count up, 0 = count down
//   carry_in      in   active-low count enable
//   preset        in   preset value
//   q             out  counter value
//   carry_out     out  active-low terminal-count decode
module MC14516B
  import mc14516b_ctrl_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            preset_enable,
  input  logic            up_down,
  input  logic            carry_in,
  input  logic [SIZE-1:0] preset,
  output logic [SIZE-1:0] q,
  output logic            carry_out
);

  logic [SIZE-1:0] w_term;

  assign w_term = SIZE'(terminal(SIZE, up_down));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (preset_enable) begin
      q <= preset;
    end else if (!carry_in) begin
      q <= up_down ? q + 1'b1 : q - 1'b1;
    end
  end

  // Pure terminal decode; the controller qualifies it with its own run enable.
  assign carry_out = (q != w_term);

endmodule

// File: rtl/mc14516b_timer_ctrl.sv
// rtl/mc14516b_timer_ctrl.sv - programmable interval timer sequencing one MC14516B
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   1-cycle run request (latches load_value/count_up/periodic)
//   stop        in   abort current run, back to IDLE
//   hold        in   level, freezes counting in RUN
//   periodic    in   1 = reload at terminal, 0 = one-shot
//   count_up    in   1 = count to all-ones, 0 = count to zero
//   load_value  in   preset value
//   busy        out  high in LOAD and RUN
//   done        out  high in DONE
//   expired     out  registered 1-cycle pulse per terminal count
//   count       out  live counter value
module mc14516b_timer_ctrl
  import mc14516b_ctrl_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            stop,
  input  logic            hold,
  input  logic            periodic,
  input  logic            count_up,
  input  logic [SIZE-1:0] load_value,
  output logic            busy,
  output logic            done,
  output logic            expired,
  output logic [SIZE-1:0] count
);

  state_t          r_state;
  state_t          w_next;
  logic [SIZE-1:0] r_load;
  logic            r_up;
  logic            r_periodic;
  logic            r_expired;

  logic [SIZE-1:0] w_term;
  logic            w_at_term;
  logic            w_run_en;
  logic            w_start_ok;
  logic            w_preset_en;
  logic            w_carry_in;
  logic            w_carry_out;
  logic            w_tc_n;
  logic            w_counter_reset;

  assign w_term     = SIZE'(terminal(SIZE, r_up));
  // Terminal is decoded from the count itself; carry_out would loop back through carry_in.
  assign w_at_term  = (count == w_term);
  assign w_run_en   = (r_state == RUN) && !hold;
  assign w_start_ok = start && !stop && ((r_state == IDLE) || (r_state == DONE));

  // Active-low terminal-reached indication, low only while enabled at terminal.
  assign w_tc_n = w_carry_out | !w_run_en;

  assign w_counter_reset = !reset_n;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: stop beats terminal beats start
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_ok) w_next = LOAD;
      end
      LOAD: begin
        w_next = stop ? IDLE : RUN;
      end
      RUN: begin
        if (stop) begin
          w_next = IDLE;
        end else if (w_run_en && w_at_term) begin
          w_next = r_periodic ? LOAD : DONE;
        end
      end
      DONE: begin
        if (stop) begin
          w_next = IDLE;
        end else if (start) begin
          w_next = LOAD;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Output / counter-drive logic
  always_comb begin
    busy        = (r_state == LOAD) || (r_state == RUN);
    done        = (r_state == DONE);
    w_preset_en = (r_state == LOAD);
    // Enable drops in the terminal cycle so the counter never wraps.
    w_carry_in  = !(w_run_en && !w_at_term);
  end

  // Run parameters are captured only on an accepted start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_load     <= '0;
      r_up       <= 1'b0;
      r_periodic <= 1'b0;
    end else if (w_start_ok) begin
      r_load     <= load_value;
      r_up       <= count_up;
      r_periodic <= periodic;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_expired <= 1'b0;
    end else begin
      r_expired <= w_run_en && w_at_term && !stop;
    end
  end

  assign expired = r_expired;

  always @(posedge clock) begin
    if (reset_n) begin
      assert (w_tc_n == !(w_run_en && w_at_term));
    end
  end

  MC14516B #(
    .SIZE(SIZE)
  ) u_counter (
    .clock        (clock),
    .reset        (w_counter_reset),
    .preset_enable(w_preset_en),
    .up_down      (r_up),
    .carry_in     (w_carry_in),
    .preset       (r_load),
    .q            (count),
    .carry_out    (w_carry_out)
  );

endmodule
